// File: rtl/mips_pkg.sv
//------------------------------------------------------------------------------
// Module   : mips_pkg
// Purpose  : Shared register-file widths, zero-register index and clear FSM states.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mips_pkg;
   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 5;
   localparam int REG_ZERO   = 0;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } clrState_t;
endpackage

`default_nettype wire

// File: rtl/banco_clear_seq.sv
//------------------------------------------------------------------------------
// Module   : banco_clear_seq
// Purpose  : Post-reset sequencer zeroing registers 1..N-1, one per cycle; drives Busy.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module banco_clear_seq
   import mips_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clock,
   input  logic              reset,
   output logic              clearEn,
   output logic [ADDR_W-1:0] clearIdx,
   output logic              Busy
);

   localparam logic [ADDR_W-1:0] c_LAST  = '1;
   localparam logic [ADDR_W-1:0] c_FIRST = ADDR_W'(1);

   clrState_t         r_state;
   clrState_t         w_stateNext;
   logic [ADDR_W-1:0] r_count;
   logic [ADDR_W-1:0] w_countNext;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= CLEAR;
         r_count <= c_FIRST;
      end else begin
         r_state <= w_stateNext;
         r_count <= w_countNext;
      end
   end

   // The counter stops at the last index so it never wraps back to register 0.
   always_comb begin
      w_stateNext = r_state;
      w_countNext = r_count;
      clearEn     = 1'b0;
      Busy        = 1'b0;
      case (r_state)
         CLEAR: begin
            Busy    = 1'b1;
            clearEn = !reset;
            if (r_count == c_LAST) begin
               w_stateNext = RUN;
            end else begin
               w_countNext = r_count + c_FIRST;
            end
         end
         RUN: begin
            w_stateNext = RUN;
         end
         default: begin
            w_stateNext = CLEAR;
         end
      endcase
   end

   assign clearIdx = r_count;

endmodule

`default_nettype wire

// File: rtl/banco_registradores.sv
//------------------------------------------------------------------------------
// Module   : banco_registradores
// Purpose  : 32x32 MIPS register file with post-reset clear; optional write-through
//            bypass enabled by macro BANCO_REG_BYPASS_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module banco_registradores
   import mips_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              RegWrite,
   input  logic [ADDR_W-1:0] Read_Reg1,
   input  logic [ADDR_W-1:0] Read_Reg2,
   input  logic [ADDR_W-1:0] Write_Reg,
   input  logic [DATA_W-1:0] Write_Data,
   output logic [DATA_W-1:0] Read_Data1,
   output logic [DATA_W-1:0] Read_Data2,
   output logic              Busy
);

   localparam logic [ADDR_W-1:0] c_ZERO = ADDR_W'(REG_ZERO);

   logic [DATA_W-1:0] r_regs [0:(1<<ADDR_W)-1];
   logic              w_clearEn;
   logic [ADDR_W-1:0] w_clearIdx;
   logic              w_wrEn;

   banco_clear_seq #(
      .ADDR_W (ADDR_W)
   ) u_clearSeq (
      .clock    (clock),
      .reset    (reset),
      .clearEn  (w_clearEn),
      .clearIdx (w_clearIdx),
      .Busy     (Busy)
   );

   assign w_wrEn = RegWrite && !Busy && (Write_Reg != c_ZERO);

   // Clear writes and core writes never coincide: core writes require Busy=0.
   always_ff @(posedge clock) begin
      if (w_clearEn) begin
         r_regs[w_clearIdx] <= '0;
      end else if (w_wrEn) begin
         r_regs[Write_Reg] <= Write_Data;
      end
   end

   always_comb begin
      Read_Data1 = '0;
      Read_Data2 = '0;
      if (!Busy && (Read_Reg1 != c_ZERO)) begin
         Read_Data1 = r_regs[Read_Reg1];
      end
      if (!Busy && (Read_Reg2 != c_ZERO)) begin
         Read_Data2 = r_regs[Read_Reg2];
      end
`ifdef BANCO_REG_BYPASS_EN
      if (w_wrEn && (Read_Reg1 == Write_Reg)) begin
         Read_Data1 = Write_Data;
      end
      if (w_wrEn && (Read_Reg2 == Write_Reg)) begin
         Read_Data2 = Write_Data;
      end
`endif
   end

endmodule

`default_nettype wire
